// File: rtl/apu_pkg.sv
// Shared constants for the APU frame sequencer: default step tick counts,
// sequence mode encoding and post-write reset delay.
package apu_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned DLY_W = 3;

    localparam int unsigned STEP1 = 7457;
    localparam int unsigned STEP2 = 14913;
    localparam int unsigned STEP3 = 22371;
    localparam int unsigned STEP4 = 29829;
    localparam int unsigned STEP5 = 37281;

    localparam int unsigned WRITE_DELAY = 3;

    localparam logic MODE_4STEP = 1'b0;
    localparam logic MODE_5STEP = 1'b1;

endpackage

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: 4/5-step tick counter issuing quarter/half-frame strobes,
// delayed counter reset after a config write, and frame IRQ (macro APU_FRAME_IRQ_EN).
module apu_frame_sequencer #(
    parameter int unsigned STEP1       = apu_pkg::STEP1,
    parameter int unsigned STEP2       = apu_pkg::STEP2,
    parameter int unsigned STEP3       = apu_pkg::STEP3,
    parameter int unsigned STEP4       = apu_pkg::STEP4,
    parameter int unsigned STEP5       = apu_pkg::STEP5,
    parameter int unsigned WRITE_DELAY = apu_pkg::WRITE_DELAY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic cfg_we,
    input  logic cfg_mode,
    input  logic cfg_irq_inhibit,
    input  logic irq_ack,
    output logic quarter_frame,
    output logic half_frame,
    output logic irq,
    output logic mode,
    output logic reset_pending
);
    import apu_pkg::*;

    localparam logic [CNT_W-1:0] S1 = CNT_W'(STEP1);
    localparam logic [CNT_W-1:0] S2 = CNT_W'(STEP2);
    localparam logic [CNT_W-1:0] S3 = CNT_W'(STEP3);
    localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);
    localparam logic [CNT_W-1:0] S5 = CNT_W'(STEP5);
    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(WRITE_DELAY);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             mode_q, mode_d;
    logic             quarter_q, quarter_d;
    logic             half_q, half_d;

    logic hit_s1, hit_s2, hit_s3, hit_s4, hit_s5;
    logic last_hit;
    logic dly_done;
    logic decode_en;

    // A tick in the write cycle restarts the delay instead of consuming it.
    always_comb begin
        hit_s1    = (cnt_q == S1);
        hit_s2    = (cnt_q == S2);
        hit_s3    = (cnt_q == S3);
        hit_s4    = (cnt_q == S4);
        hit_s5    = (cnt_q == S5);
        last_hit  = (mode_q == MODE_5STEP) ? hit_s5 : hit_s4;
        dly_done  = tick && !cfg_we && (dly_q == DLY_ONE);
        decode_en = tick && !dly_done;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            if (dly_done || last_hit) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        dly_d = dly_q;
        if (cfg_we) begin
            dly_d = DLY_INIT;
        end else if (tick && (dly_q != '0)) begin
            dly_d = dly_q - DLY_ONE;
        end
    end

    assign mode_d = cfg_we ? cfg_mode : mode_q;

    // Step decode uses the mode in effect before any same-cycle write.
    always_comb begin
        quarter_d = 1'b0;
        half_d    = 1'b0;
        if (decode_en) begin
            case (mode_q)
                MODE_4STEP: begin
                    quarter_d = hit_s1 | hit_s2 | hit_s3 | hit_s4;
                    half_d    = hit_s2 | hit_s4;
                end
                MODE_5STEP: begin
                    quarter_d = hit_s1 | hit_s2 | hit_s3 | hit_s5;
                    half_d    = hit_s2 | hit_s5;
                end
                default: begin
                    quarter_d = 1'b0;
                    half_d    = 1'b0;
                end
            endcase
        end
        if (dly_done && (mode_q == MODE_5STEP)) begin
            quarter_d = 1'b1;
            half_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            dly_q     <= '0;
            mode_q    <= 1'b0;
            quarter_q <= 1'b0;
            half_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dly_q     <= dly_d;
            mode_q    <= mode_d;
            quarter_q <= quarter_d;
            half_q    <= half_d;
        end
    end

`ifdef APU_FRAME_IRQ_EN
    logic inhibit_q, inhibit_d;
    logic irq_q, irq_d;
    logic irq_set, irq_clr;

    // Set beats clear when both land on the same edge.
    always_comb begin
        irq_set   = decode_en && (mode_q == MODE_4STEP) && hit_s4 && !inhibit_q;
        irq_clr   = irq_ack || (cfg_we && cfg_irq_inhibit);
        irq_d     = irq_set || (irq_q && !irq_clr);
        inhibit_d = cfg_we ? cfg_irq_inhibit : inhibit_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inhibit_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            inhibit_q <= inhibit_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = cfg_irq_inhibit ^ irq_ack;
    assign irq = 1'b0;
`endif

    assign quarter_frame = quarter_q;
    assign half_frame    = half_q;
    assign mode          = mode_q;
    assign reset_pending = (dly_q != '0);

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer with shortened step counts; tracks IRQ
// expectations for both builds of APU_FRAME_IRQ_EN.
module tb_apu_frame_sequencer;

    localparam int S1 = 11;
    localparam int S2 = 23;
    localparam int S3 = 35;
    localparam int S4 = 47;
    localparam int S5 = 59;
    localparam int WD = 3;

`ifdef APU_FRAME_IRQ_EN
    localparam logic IrqEn = 1'b1;
`else
    localparam logic IrqEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic cfg_we = 1'b0;
    logic cfg_mode = 1'b0;
    logic cfg_irq_inhibit = 1'b0;
    logic irq_ack = 1'b0;
    logic quarter_frame, half_frame, irq, mode, reset_pending;

    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    int   exp_dly = 0;
    logic exp_mode = 1'b0;

    always #5 clk = ~clk;

    apu_frame_sequencer #(
        .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5), .WRITE_DELAY(WD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick(tick),
        .cfg_we(cfg_we),
        .cfg_mode(cfg_mode),
        .cfg_irq_inhibit(cfg_irq_inhibit),
        .irq_ack(irq_ack),
        .quarter_frame(quarter_frame),
        .half_frame(half_frame),
        .irq(irq),
        .mode(mode),
        .reset_pending(reset_pending)
    );

    function automatic logic exp_q(input int c, input logic md);
        return (c == S1) || (c == S2) || (c == S3) || (c == (md ? S5 : S4));
    endfunction

    function automatic logic exp_h(input int c, input logic md);
        return (c == S2) || (c == (md ? S5 : S4));
    endfunction

    // Applies inputs for one clk edge (driven and sampled at negedge) and
    // advances the bench's counter model.
    task automatic drive(input logic t, input logic we, input logic m, input logic inh,
                         input logic ack);
        tick = t; cfg_we = we; cfg_mode = m; cfg_irq_inhibit = inh; irq_ack = ack;
        @(negedge clk);
        tick = 0; cfg_we = 0; cfg_mode = 0; cfg_irq_inhibit = 0; irq_ack = 0;
        if (t) begin
            if (!we && exp_dly == 1) exp_cnt = 0;
            else if (exp_cnt == (exp_mode ? S5 : S4)) exp_cnt = 0;
            else exp_cnt++;
            if (!we && exp_dly > 0) exp_dly--;
        end
        if (we) begin
            exp_dly  = WD;
            exp_mode = m;
        end
    endtask

    // One tick with strobe checks against the step table.
    task automatic tick_check(input string tag);
        int   c;
        logic md;
        c  = exp_cnt;
        md = exp_mode;
        drive(1, 0, 0, 0, 0);
        checks += 2;
        if (quarter_frame !== exp_q(c, md)) begin
            errors++;
            $display("FAIL %s quarter cnt=%0d got=%b exp=%b", tag, c, quarter_frame, exp_q(c, md));
        end
        if (half_frame !== exp_h(c, md)) begin
            errors++;
            $display("FAIL %s half cnt=%0d got=%b exp=%b", tag, c, half_frame, exp_h(c, md));
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks += 5;
        if (quarter_frame !== 1'b0) begin errors++; $display("FAIL reset quarter got=%b exp=0", quarter_frame); end
        if (half_frame !== 1'b0) begin errors++; $display("FAIL reset half got=%b exp=0", half_frame); end
        if (irq !== 1'b0) begin errors++; $display("FAIL reset irq got=%b exp=0", irq); end
        if (mode !== 1'b0) begin errors++; $display("FAIL reset mode got=%b exp=0", mode); end
        if (reset_pending !== 1'b0) begin errors++; $display("FAIL reset pending got=%b exp=0", reset_pending); end
    endtask

    task automatic test_four_step();
        for (int k = 0; k <= S4 + S1 + 1; k++) begin
            logic strobe;
            strobe = exp_q(exp_cnt, exp_mode);
            tick_check("four_step");
            drive(0, 0, 0, 0, 0);
            if (strobe) begin
                checks++;
                if (quarter_frame !== 1'b0) begin
                    errors++;
                    $display("FAIL four_step_width quarter got=%b exp=0", quarter_frame);
                end
            end
            if (k == S4) begin
                checks++;
                if (irq !== IrqEn) begin errors++; $display("FAIL four_step irq got=%b exp=%b", irq, IrqEn); end
            end
            repeat (5) drive(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_irq_ack();
        drive(0, 0, 0, 0, 1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_ack clear got=%b exp=0", irq); end
        while (exp_cnt != S4) drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1);
        checks += 2;
        if (irq !== IrqEn) begin errors++; $display("FAIL irq_set_wins got=%b exp=%b", irq, IrqEn); end
        if (quarter_frame !== 1'b1) begin errors++; $display("FAIL irq_set_wins quarter got=%b exp=1", quarter_frame); end
        drive(0, 1, 0, 1, 0);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL inhibit_clear irq got=%b exp=0", irq); end
        repeat (3) tick_check("inhibit_delay");
        while (exp_cnt != S4) drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        checks += 2;
        if (irq !== 1'b0) begin errors++; $display("FAIL inhibit_hold irq got=%b exp=0", irq); end
        if (half_frame !== 1'b1) begin errors++; $display("FAIL inhibit_hold half got=%b exp=1", half_frame); end
    endtask

    task automatic test_five_step();
        drive(0, 1, 1, 0, 0);
        checks += 2;
        if (mode !== 1'b1) begin errors++; $display("FAIL five_write mode got=%b exp=1", mode); end
        if (reset_pending !== 1'b1) begin errors++; $display("FAIL five_write pending got=%b exp=1", reset_pending); end
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 0, 0, 0);
            checks += 2;
            if (reset_pending !== (i < 3)) begin
                errors++;
                $display("FAIL five_delay pending tick=%0d got=%b exp=%b", i, reset_pending, i < 3);
            end
            if (quarter_frame !== (i == 3) || half_frame !== (i == 3)) begin
                errors++;
                $display("FAIL five_delay strobes tick=%0d got=%b%b exp=%b%b", i, quarter_frame,
                         half_frame, i == 3, i == 3);
            end
        end
        for (int k = 0; k < 3 * (S5 + 1); k++) begin
            tick_check("five_step");
            checks++;
            if (irq !== 1'b0) begin errors++; $display("FAIL five_step irq got=%b exp=0", irq); end
        end
    endtask

    task automatic test_write_old_mode();
        while (exp_cnt != S4) drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        checks += 4;
        if (quarter_frame !== 1'b0) begin errors++; $display("FAIL old_mode quarter got=%b exp=0", quarter_frame); end
        if (irq !== 1'b0) begin errors++; $display("FAIL old_mode irq got=%b exp=0", irq); end
        if (mode !== 1'b0) begin errors++; $display("FAIL old_mode mode got=%b exp=0", mode); end
        if (reset_pending !== 1'b1) begin errors++; $display("FAIL old_mode pending got=%b exp=1", reset_pending); end
        repeat (2) drive(1, 0, 0, 0, 0);
        checks++;
        if (reset_pending !== 1'b1) begin errors++; $display("FAIL old_mode pending2 got=%b exp=1", reset_pending); end
        drive(1, 0, 0, 0, 0);
        checks += 2;
        if (reset_pending !== 1'b0) begin errors++; $display("FAIL old_mode done pending got=%b exp=0", reset_pending); end
        if (quarter_frame !== 1'b0 || half_frame !== 1'b0) begin
            errors++;
            $display("FAIL old_mode done strobes got=%b%b exp=00", quarter_frame, half_frame);
        end
        for (int k = 0; k <= S4; k++) tick_check("after_reset4");
        checks++;
        if (irq !== IrqEn) begin errors++; $display("FAIL after_reset4 irq got=%b exp=%b", irq, IrqEn); end
    endtask

    task automatic test_rewrite();
        drive(0, 1, 1, 0, 0);
        repeat (2) drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        checks += 2;
        if (mode !== 1'b0) begin errors++; $display("FAIL rewrite mode got=%b exp=0", mode); end
        if (reset_pending !== 1'b1) begin errors++; $display("FAIL rewrite pending got=%b exp=1", reset_pending); end
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 0, 0, 0);
            checks += 2;
            if (reset_pending !== (i < 3)) begin
                errors++;
                $display("FAIL rewrite restart tick=%0d got=%b exp=%b", i, reset_pending, i < 3);
            end
            if (quarter_frame !== 1'b0 || half_frame !== 1'b0) begin
                errors++;
                $display("FAIL rewrite strobes tick=%0d got=%b%b exp=00", i, quarter_frame, half_frame);
            end
        end
    endtask

    task automatic test_async_reset();
        while (exp_cnt != S1) drive(1, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0);
        checks += 2;
        if (quarter_frame !== 1'b1) begin errors++; $display("FAIL pre_reset quarter got=%b exp=1", quarter_frame); end
        if (reset_pending !== 1'b1) begin errors++; $display("FAIL pre_reset pending got=%b exp=1", reset_pending); end
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (quarter_frame !== 1'b0) begin errors++; $display("FAIL async quarter got=%b exp=0", quarter_frame); end
        if (half_frame !== 1'b0) begin errors++; $display("FAIL async half got=%b exp=0", half_frame); end
        if (irq !== 1'b0) begin errors++; $display("FAIL async irq got=%b exp=0", irq); end
        if (mode !== 1'b0) begin errors++; $display("FAIL async mode got=%b exp=0", mode); end
        if (reset_pending !== 1'b0) begin errors++; $display("FAIL async pending got=%b exp=0", reset_pending); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0; exp_dly = 0; exp_mode = 1'b0;
        drive(0, 0, 0, 0, 0);
        checks++;
        if (quarter_frame !== 1'b0 || half_frame !== 1'b0) begin
            errors++;
            $display("FAIL release strobes got=%b%b exp=00", quarter_frame, half_frame);
        end
        for (int k = 0; k <= S1; k++) tick_check("post_release");
        checks++;
        if (quarter_frame !== 1'b1) begin errors++; $display("FAIL post_release first quarter got=%b exp=1", quarter_frame); end
    endtask

    initial begin
        test_reset();
        test_four_step();
        test_irq_ack();
        test_five_step();
        test_write_old_mode();
        test_rewrite();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apu_frame_sequencer.md
Name: apu_frame_sequencer

Overview:
- Frame sequencer for the APU. Counts CPU-rate ticks derived from the prescaler's apu_clk domain.
- Issues quarter-frame and half-frame strobes to the envelope, length and sweep units, plus a frame IRQ.
- Configured by a $4017-style register write from the UART command decoder. Provides 4-step and 5-step sequences with a delayed counter reset after each write.

Parameters:
- STEP1, 7457, tick count of step 1 (quarter)
- STEP2, 14913, tick count of step 2 (quarter + half)
- STEP3, 22371, tick count of step 3 (quarter)
- STEP4, 29829, tick count of step 4 (4-step: quarter + half + IRQ; also wrap point)
- STEP5, 37281, tick count of step 5 (5-step: quarter + half; also wrap point)
- WRITE_DELAY, 3, ticks between cfg write and counter reset (range 1..7)

Ports:
- clk  in  1  system clock (12 MHz oscillator domain)
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-clk enable pulse, one per APU CPU cycle (about 1.79 MHz)
- cfg_we  in  1  one-clk write strobe for the frame-counter register
- cfg_mode  in  1  0 = 4-step, 1 = 5-step; sampled on cfg_we
- cfg_irq_inhibit  in  1  1 = suppress and clear the frame IRQ; sampled on cfg_we
- irq_ack  in  1  one-clk IRQ clear (status read)
- quarter_frame  out  1  one-clk strobe
- half_frame  out  1  one-clk strobe
- irq  out  1  frame IRQ flag, level
- mode  out  1  current sequence mode
- reset_pending  out  1  high while the post-write delay is running

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. The reset values of all outputs, cnt, mode, inhibit and the delay counter are 0.
- Counter: cnt is 16 bits and changes only on a tick cycle.
  - If cnt == LAST, then cnt <= 0. Otherwise cnt <= cnt + 1.
  - LAST = STEP4 in 4-step mode and STEP5 in 5-step mode.
  - Counter arithmetic does not saturate. Wrap occurs only at LAST.
- Strobes: outputs are registered. On a tick cycle where cnt equals a step value, the strobe is high for exactly one clk on the following cycle (latency 1 clk).
  - 4-step: quarter at STEP1, STEP2, STEP3, STEP4; half at STEP2 and STEP4.
  - 5-step: quarter at STEP1, STEP2, STEP3, STEP5; half at STEP2 and STEP5. STEP4 produces nothing.
  - No strobes are issued when tick = 0.
- IRQ:
  - Set on the tick at cnt == STEP4 in 4-step mode when inhibit = 0, visible 1 clk later.
  - Never set in 5-step mode.
  - Cleared by irq_ack, or by cfg_we with cfg_irq_inhibit = 1.
  - If set and clear occur in the same cycle, set wins.
- Config write (cfg_we):
  - mode and inhibit load on the same edge.
  - A tick in the same cycle as cfg_we is decoded with the old mode.
  - The delay counter loads WRITE_DELAY and reset_pending goes high.
- Pending reset:
  - Normal stepping continues during the delay.
  - Each tick decrements the delay counter. A tick in the write cycle does not count.
  - On the tick that takes the delay counter to 0: cnt <= 0, and that tick's step decode is suppressed.
  - If mode = 1, quarter and half both pulse on the next cycle.
  - reset_pending drops on the same edge.
- A new cfg_we during pending restarts the delay and takes the new values.
- rst_n assertion mid-sequence or mid-delay: all state clears immediately, with no strobe on release.

Optional Feature:
- Macro: APU_FRAME_IRQ_EN.
- Defined: the IRQ logic described above is present.
- Undefined: irq is tied to 0, no inhibit register is built, and cfg_irq_inhibit and irq_ack are ignored. Strobe timing is unchanged.

Decomposition:
- Shared package / include file apu_pkg holds:
  - the default step constants STEP1–STEP5
  - the mode encoding constants MODE_4STEP = 0 and MODE_5STEP = 1
  - WRITE_DELAY
- No sub-module is required. The step comparator and strobe encode stay inline.

Test Plan:
- Reset, then tick every 7th clk in 4-step mode:
  - quarter at cnt 7457, 14913, 22371, 29829
  - half at 14913 and 29829
  - irq rises after 29829
  - cnt wraps to 0 on the next tick
- Write mode = 1, inhibit = 0, then free-run: no quarter or half at 29829, quarter + half at 37281, wrap to 0, irq stays 0 for 3 frames.
- 4-step with irq set, then irq_ack → irq = 0 the next clk. Repeat with irq_ack on the STEP4 tick edge → irq stays 1.
- cfg_we (mode = 1) at cnt = 1000:
  - reset_pending is high for 3 ticks
  - on the 3rd tick, cnt → 0 and quarter + half pulse once
  - the next quarter arrives 7457 ticks later
- cfg_we at delay = 1, then a second cfg_we (mode = 0): the delay restarts at 3, and no immediate strobes occur on completion.
- Assert rst_n low at cnt = 14912 with reset_pending = 1: all outputs are 0 asynchronously, and the first quarter after release comes at tick 7457.
